dsp48_mac_sequencer: RTL and testbench

- Drives a single DSP48 slice as a multiply-accumulate engine.
- Accepts a valid/ready stream of 18-bit operand pairs and issues each pair to the slice's A/B inputs.
- Generates the aligned opmode and clock-enable controls, drains the slice pipeline after the last term of a group, and returns each N_TAPS-term dot product on a 48-bit valid/ready result port.
- Sits between the sample/coefficient source and the slice; it is the control side of the slice's operand/opmode interface.

---
 rtl/dsp48_mac_sequencer.sv | 144 ++++++++++++++
 tb/tb_dsp48_mac_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48_mac_sequencer.sv
// Control side of a DSP48 slice used as an N_TAPS-term multiply-accumulate engine:
// streams operand pairs into A/B, aligns opmode, drains the pipeline and returns each dot product.
module dsp48_mac_sequencer #(
   parameter int unsigned N_TAPS   = 4,
   parameter int unsigned PIPE_LAT = 3,
   parameter int unsigned OPM_DLY  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [17:0] s_a,
   input  logic [17:0] s_b,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [47:0] m_data,
   output logic [17:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic [7:0]  dsp_opmode,
   output logic        dsp_ce,
   output logic        dsp_rst,
   input  logic [47:0] dsp_p,
   output logic        busy
);

   localparam int unsigned TC_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int unsigned DC_W = $clog2(PIPE_LAT);
   localparam int unsigned DL_W = (OPM_DLY > 0) ? OPM_DLY : 1;

   typedef enum logic [1:0] {
      ACCUM,
      DRAIN,
      OUT
   } state_t;

   state_t            state_q, state_d;
   logic [TC_W-1:0]   term_q, term_d;
   logic [DC_W-1:0]   drain_q, drain_d;
   logic              m_valid_q, m_valid_d;
   logic [47:0]       m_data_q, m_data_d;
   logic [DL_W-1:0]   dl_first_q, dl_first_d;
   logic [DL_W-1:0]   dl_live_q, dl_live_d;

   logic              push_first;
   logic              tap_first;
   logic              tap_live;

   always_comb begin
      state_d    = state_q;
      term_d     = term_q;
      drain_d    = drain_q;
      m_valid_d  = m_valid_q && !m_ready;
      m_data_d   = m_data_q;
      dl_first_d = dl_first_q;
      dl_live_d  = dl_live_q;
      s_ready    = 1'b0;
      dsp_ce     = 1'b0;
      dsp_a      = '0;
      dsp_b      = '0;
      push_first = 1'b0;

      case (state_q)
         ACCUM: begin
            s_ready = 1'b1;
            dsp_ce  = s_valid;
            if (s_valid) begin
               dsp_a      = s_a;
               dsp_b      = s_b;
               push_first = (term_q == '0);
               if (term_q == TC_W'(N_TAPS - 1)) begin
                  term_d  = '0;
                  drain_d = DC_W'(PIPE_LAT - 1);
                  state_d = DRAIN;
               end else begin
                  term_d = term_q + TC_W'(1);
               end
            end
         end
         DRAIN: begin
            dsp_ce  = 1'b1;
            drain_d = drain_q - DC_W'(1);
            if (drain_q == DC_W'(1)) begin
               state_d = OUT;
            end
         end
         OUT: begin
            // capture wins over the handshake clear, so m_valid stays high back-to-back
            if (!m_valid_q || m_ready) begin
               m_data_d  = dsp_p;
               m_valid_d = 1'b1;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      // live marks entries that came from a real advance step; unfilled taps give opmode 00
      if (dsp_ce) begin
         dl_first_d[0] = push_first;
         dl_live_d[0]  = 1'b1;
         for (int unsigned i = 1; i < DL_W; i++) begin
            dl_first_d[i] = dl_first_q[i-1];
            dl_live_d[i]  = dl_live_q[i-1];
         end
      end
   end

   generate
      if (OPM_DLY == 0) begin : g_tap_now
         assign tap_first = push_first;
         assign tap_live  = dsp_ce;
      end else begin : g_tap_dly
         assign tap_first = dl_first_q[OPM_DLY-1];
         assign tap_live  = dl_live_q[OPM_DLY-1];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ACCUM;
         term_q     <= '0;
         drain_q    <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         dl_first_q <= '0;
         dl_live_q  <= '0;
      end else begin
         state_q    <= state_d;
         term_q     <= term_d;
         drain_q    <= drain_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         dl_first_q <= dl_first_d;
         dl_live_q  <= dl_live_d;
      end
   end

   assign dsp_opmode = !tap_live ? 8'h00 : (tap_first ? 8'h01 : 8'h09);
   assign dsp_rst    = RST;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign busy       = (state_q != ACCUM) || (term_q != '0);

endmodule

// File: tb/tb_dsp48_mac_sequencer.sv
// Bench for dsp48_mac_sequencer: a behavioural DSP48 slice closes the loop, a dot-product
// model checks every cycle, and directed groups pin results with literal values.
module tb_dsp48_mac_sequencer;

   localparam int unsigned N_TAPS   = 4;
   localparam int unsigned PIPE_LAT = 3;
   localparam int unsigned OPM_DLY  = 1;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [17:0] s_a = '0;
   logic [17:0] s_b = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [47:0] m_data;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_ce;
   logic        dsp_rst;
   logic [47:0] dsp_p;
   logic        busy;

   dsp48_mac_sequencer #(
      .N_TAPS  (N_TAPS),
      .PIPE_LAT(PIPE_LAT),
      .OPM_DLY (OPM_DLY)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_a       (s_a),
      .s_b       (s_b),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .dsp_a     (dsp_a),
      .dsp_b     (dsp_b),
      .dsp_opmode(dsp_opmode),
      .dsp_ce    (dsp_ce),
      .dsp_rst   (dsp_rst),
      .dsp_p     (dsp_p),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   // Slice: A1/B1 -> M -> P, opmode registered alongside A1 so it meets M at the P stage.
   logic [17:0] a1, b1;
   logic [47:0] mreg, preg;
   logic [7:0]  opm_r;
   always @(posedge CLK) begin
      if (dsp_rst) begin
         a1 <= '0; b1 <= '0; mreg <= '0; preg <= '0; opm_r <= '0;
      end else if (dsp_ce) begin
         a1    <= dsp_a;
         b1    <= dsp_b;
         mreg  <= 48'(a1) * 48'(b1);
         opm_r <= dsp_opmode;
         preg  <= (opm_r[3] ? preg : 48'd0) + (opm_r[0] ? mreg : 48'd0);
      end
   end
   assign dsp_p = preg;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Dot-product model: sum each N_TAPS accepted pairs; results leave in order.
   int unsigned grp_n = 0;
   logic [47:0] grp_sum = '0;
   logic [47:0] exp_q[$];
   bit          first_hist[$];
   int unsigned step = 0;
   bit          acc, fst;
   logic [47:0] got[$];

   always @(negedge CLK) begin
      chk("dsp_rst", {47'd0, dsp_rst}, {47'd0, RST});
      if (RST) begin
         grp_n = 0; grp_sum = '0; exp_q.delete(); first_hist.delete(); step = 0;
      end else begin
         acc = s_valid && s_ready;
         fst = acc && (grp_n == 0);
         if (acc) begin
            chk("accept_ce", {47'd0, dsp_ce}, 48'd1);
            chk("accept_a", {30'd0, dsp_a}, {30'd0, s_a});
            chk("accept_b", {30'd0, dsp_b}, {30'd0, s_b});
            grp_sum = grp_sum + 48'(s_a) * 48'(s_b);
            grp_n++;
            if (grp_n == N_TAPS) begin
               exp_q.push_back(grp_sum);
               grp_n = 0; grp_sum = '0;
            end
         end else if (s_ready) begin
            chk("bubble_ce", {47'd0, dsp_ce}, 48'd0);
            chk("bubble_a", {30'd0, dsp_a}, 48'd0);
         end
         if (dsp_ce) begin
            first_hist.push_back(fst);
            if (step >= OPM_DLY)
               chk("opmode", {40'd0, dsp_opmode},
                   first_hist[step - OPM_DLY] ? 48'h01 : 48'h09);
            step++;
         end
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL spurious_m_valid: got m_data 0x%0h expected no result at %0t", m_data, $time);
            end else begin
               chk("m_data_model", m_data, exp_q[0]);
               if (m_ready) void'(exp_q.pop_front());
            end
         end
         if (m_valid && m_ready) got.push_back(m_data);
      end
   end

   task automatic send(input logic [17:0] a, input logic [17:0] b, input int gap);
      bit ok;
      s_valid = 1'b1; s_a = a; s_b = b;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLK);
         ok = s_ready;
         @(posedge CLK); #1;
         if (ok) break;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: got s_ready 0 expected 1 within 200 cycles");
      end
      s_valid = 1'b0; s_a = '0; s_b = '0;
      repeat (gap) begin @(posedge CLK); #1; end
   endtask

   task automatic send_group(input logic [17:0] av[4], input logic [17:0] bv[4], input int gap);
      for (int i = 0; i < 4; i++) send(av[i], bv[i], gap);
   endtask

   task automatic wait_got(input int idx, input logic [47:0] exp, input string name);
      for (int i = 0; i < 300 && got.size() <= idx; i++) @(negedge CLK);
      if (got.size() > idx) chk(name, got[idx], exp);
      else begin
         n_checks++; n_fail++;
         $display("FAIL %s: got no result expected 0x%0h (timeout)", name, exp);
      end
   endtask

   logic [17:0] pa[4] = '{18'd1, 18'd3, 18'd5, 18'd7};
   logic [17:0] pb[4] = '{18'd2, 18'd4, 18'd6, 18'd8};
   logic [17:0] big[4] = '{18'h20000, 18'h20000, 18'h20000, 18'h20000};
   logic [17:0] one[4] = '{18'd1, 18'd1, 18'd1, 18'd1};
   logic [17:0] two[4] = '{18'd2, 18'd2, 18'd2, 18'd2};
   logic [17:0] thr[4] = '{18'd3, 18'd3, 18'd3, 18'd3};
   int base, lows, mvs;
   logic [47:0] seen;

   initial begin
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_s_ready", {47'd0, s_ready}, 48'd1);
      chk("rst_m_valid", {47'd0, m_valid}, 48'd0);
      chk("rst_m_data", m_data, 48'd0);
      chk("rst_dsp_ce", {47'd0, dsp_ce}, 48'd0);
      chk("rst_dsp_a", {30'd0, dsp_a}, 48'd0);
      chk("rst_opmode", {40'd0, dsp_opmode}, 48'd0);
      chk("rst_busy", {47'd0, busy}, 48'd0);
      @(posedge CLK); #1;

      // back-to-back group; s_ready must be low exactly PIPE_LAT cycles
      base = got.size();
      send(pa[0], pb[0], 0);
      send(pa[1], pb[1], 0);
      @(negedge CLK);
      chk("busy_mid_group", {47'd0, busy}, 48'd1);
      @(posedge CLK); #1;
      send(pa[2], pb[2], 0);
      send(pa[3], pb[3], 0);
      lows = 0; mvs = 0; seen = '0;
      repeat (10) begin
         @(negedge CLK);
         if (!s_ready) lows++;
         if (m_valid) begin mvs++; seen = m_data; end
      end
      chk("t1_ready_low", 48'(lows), 48'(PIPE_LAT));
      chk("t1_mvalid_pulse", 48'(mvs), 48'd1);
      chk("t1_result", seen, 48'd100);
      @(posedge CLK); #1;

      // bubbles between terms
      base = got.size();
      send_group(pa, pb, 3);
      wait_got(base, 48'd100, "t2_result");
      @(posedge CLK); #1;

      // two groups back to back
      base = got.size();
      send_group(big, big, 0);
      send_group(one, one, 0);
      wait_got(base, 48'h0010_0000_0000, "t3_result_big");
      wait_got(base + 1, 48'd4, "t3_result_ones");
      @(posedge CLK); #1;

      // backpressure: second group stalls in OUT behind the first result
      m_ready = 1'b0;
      base = got.size();
      send_group(two, thr, 0);
      for (int i = 0; i < 50 && !m_valid; i++) @(negedge CLK);
      @(posedge CLK); #1;
      send_group(pa, pb, 0);
      repeat (6) begin @(posedge CLK); #1; end
      @(negedge CLK);
      chk("t4_hold_valid", {47'd0, m_valid}, 48'd1);
      chk("t4_hold_data", m_data, 48'd24);
      chk("t4_stall_busy", {47'd0, busy}, 48'd1);
      chk("t4_stall_ready", {47'd0, s_ready}, 48'd0);
      @(posedge CLK); #1;
      m_ready = 1'b1;
      @(negedge CLK);
      chk("t6_pre_data", m_data, 48'd24);
      @(negedge CLK);
      chk("t6_valid_kept", {47'd0, m_valid}, 48'd1);
      chk("t6_new_data", m_data, 48'd100);
      @(negedge CLK);
      chk("t6_valid_clear", {47'd0, m_valid}, 48'd0);
      wait_got(base, 48'd24, "t4_first");
      wait_got(base + 1, 48'd100, "t4_second");
      @(posedge CLK); #1;

      // reset in the middle of a group
      send(pa[0], pb[0], 0);
      send(pa[1], pb[1], 0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("t5_m_valid", {47'd0, m_valid}, 48'd0);
      chk("t5_busy", {47'd0, busy}, 48'd0);
      @(posedge CLK); #1;
      base = got.size();
      send_group(pa, pb, 0);
      wait_got(base, 48'd100, "t5_result");
      repeat (4) @(negedge CLK);
      chk("all_results_out", 48'(exp_q.size()), 48'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
